// File: rtl/usb_tx_packet_framer.sv
// ---------------------------------------------------------------------------
// usb_tx_packet_framer
// Turns a protocol-controller TX_Packet request (ACK / NAK / DATA) into the
// byte stream of a complete USB packet: SYNC, PID, payload pulled from the
// data buffer, inverted CRC16 (low byte first), then an EOP request to the
// bit-level serializer. Tracks the DATA0/DATA1 toggle across packets.
//
// Ports
//   clk, n_rst           clock (rising edge), async active-low reset
//   TX_Packet            request level: 0 IDLE, 1 SEND_DATA, 2 NAK, 3 ACK
//   TX_Packet_Data_Size  payload length, sampled at packet start
//   TX_Packet_Data       buffer read data, valid the cycle after the pop
//   ack_received         host ACKed the last DATA packet (pulse)
//   Get_TX_Packet_Data   buffer pop strobe (pulse)
//   tx_byte/_valid/_ready  byte handshake to the serializer
//   tx_eop / tx_eop_done EOP request, held until the serializer finishes it
//   tx_busy              high whenever a packet is in progress
//   tx_done              pulse when the packet is complete
// ---------------------------------------------------------------------------
module usb_tx_packet_framer #(
    parameter int         MAX_BYTES = 64,
    parameter logic [7:0] SYNC_BYTE = 8'h80
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [1:0] TX_Packet,
    input  logic [6:0] TX_Packet_Data_Size,
    input  logic [7:0] TX_Packet_Data,
    input  logic       ack_received,
    output logic       Get_TX_Packet_Data,
    output logic [7:0] tx_byte,
    output logic       tx_byte_valid,
    input  logic       tx_byte_ready,
    output logic       tx_eop,
    input  logic       tx_eop_done,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_SYNC   = 4'd1;
    localparam logic [3:0] S_PID    = 4'd2;
    localparam logic [3:0] S_FETCH  = 4'd3;
    localparam logic [3:0] S_LOAD   = 4'd4;
    localparam logic [3:0] S_DATA   = 4'd5;
    localparam logic [3:0] S_CRC_LO = 4'd6;
    localparam logic [3:0] S_CRC_HI = 4'd7;
    localparam logic [3:0] S_EOP    = 4'd8;
    localparam logic [3:0] S_DONE   = 4'd9;

    localparam logic [1:0] PKT_IDLE = 2'd0;
    localparam logic [1:0] PKT_DATA = 2'd1;
    localparam logic [1:0] PKT_NAK  = 2'd2;

    localparam logic [6:0] MAX_CNT  = 7'(MAX_BYTES);

    // Reflected CRC16 (poly 0xA001), one byte folded in LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in,
                                               input logic [7:0]  data);
        logic [15:0] c;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ 16'hA001;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    logic [3:0]  state_q, state_d;
    logic [1:0]  type_q, type_d;
    logic [6:0]  count_q, count_d;
    logic [7:0]  pid_q, pid_d;
    logic [15:0] crc_q, crc_d;
    logic        armed_q, armed_d;
    logic        toggle_q, toggle_d;
    logic        last_data_q, last_data_d;
    logic [7:0]  byte_q, byte_d;
    logic        valid_q, valid_d;
    logic        get_q, get_d;
    logic        eop_q, eop_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        xfer_s;

    assign xfer_s = valid_q && tx_byte_ready;

    // Next-state and next-output computation for the packet sequencer.
    always_comb begin
        state_d     = state_q;
        type_d      = type_q;
        count_d     = count_q;
        pid_d       = pid_q;
        crc_d       = crc_q;
        armed_d     = armed_q;
        toggle_d    = toggle_q;
        last_data_d = last_data_q;
        byte_d      = byte_q;
        valid_d     = valid_q;
        get_d       = 1'b0;
        eop_d       = eop_q;
        done_d      = 1'b0;

        // The PID was already chosen at start, so a flip here only affects later packets.
        if (ack_received && last_data_q) begin
            toggle_d = ~toggle_q;
        end else begin
            toggle_d = toggle_q;
        end

        case (state_q)
            S_IDLE: begin
                if (TX_Packet == PKT_IDLE) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    armed_d = 1'b0;
                    type_d  = TX_Packet;
                    count_d = (TX_Packet_Data_Size > MAX_CNT) ? MAX_CNT : TX_Packet_Data_Size;
                    case (TX_Packet)
                        PKT_DATA: pid_d = toggle_q ? 8'h4B : 8'hC3;
                        PKT_NAK:  pid_d = 8'h5A;
                        default:  pid_d = 8'hD2;
                    endcase
                    byte_d  = SYNC_BYTE;
                    valid_d = 1'b1;
                    state_d = S_SYNC;
                end else begin
                    armed_d = 1'b0;
                end
            end
            S_SYNC: begin
                if (xfer_s) begin
                    byte_d  = pid_q;
                    state_d = S_PID;
                end else begin
                    state_d = S_SYNC;
                end
            end
            S_PID: begin
                if (!xfer_s) begin
                    state_d = S_PID;
                end else if (type_q != PKT_DATA) begin
                    valid_d = 1'b0;
                    eop_d   = 1'b1;
                    state_d = S_EOP;
                end else if (count_q == 7'd0) begin
                    byte_d  = ~crc_q[7:0];
                    state_d = S_CRC_LO;
                end else begin
                    valid_d = 1'b0;
                    get_d   = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                byte_d  = TX_Packet_Data;
                crc_d   = crc16_byte(crc_q, TX_Packet_Data);
                valid_d = 1'b1;
                state_d = S_DATA;
            end
            S_DATA: begin
                if (!xfer_s) begin
                    state_d = S_DATA;
                end else if (count_q != 7'd1) begin
                    count_d = count_q - 7'd1;
                    valid_d = 1'b0;
                    get_d   = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    count_d = 7'd0;
                    byte_d  = ~crc_q[7:0];
                    state_d = S_CRC_LO;
                end
            end
            S_CRC_LO: begin
                if (xfer_s) begin
                    byte_d  = ~crc_q[15:8];
                    state_d = S_CRC_HI;
                end else begin
                    state_d = S_CRC_LO;
                end
            end
            S_CRC_HI: begin
                if (xfer_s) begin
                    valid_d = 1'b0;
                    eop_d   = 1'b1;
                    state_d = S_EOP;
                end else begin
                    state_d = S_CRC_HI;
                end
            end
            S_EOP: begin
                if (tx_eop_done) begin
                    eop_d       = 1'b0;
                    done_d      = 1'b1;
                    last_data_d = (type_q == PKT_DATA);
                    state_d     = S_DONE;
                end else begin
                    state_d = S_EOP;
                end
            end
            S_DONE: begin
                crc_d   = 16'hFFFF;
                state_d = S_IDLE;
            end
            default: begin
                valid_d = 1'b0;
                eop_d   = 1'b0;
                crc_d   = 16'hFFFF;
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and registered-output update.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= S_IDLE;
            type_q      <= 2'd0;
            count_q     <= 7'd0;
            pid_q       <= 8'h00;
            crc_q       <= 16'hFFFF;
            armed_q     <= 1'b1;
            toggle_q    <= 1'b0;
            last_data_q <= 1'b0;
            byte_q      <= 8'h00;
            valid_q     <= 1'b0;
            get_q       <= 1'b0;
            eop_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            type_q      <= type_d;
            count_q     <= count_d;
            pid_q       <= pid_d;
            crc_q       <= crc_d;
            armed_q     <= armed_d;
            toggle_q    <= toggle_d;
            last_data_q <= last_data_d;
            byte_q      <= byte_d;
            valid_q     <= valid_d;
            get_q       <= get_d;
            eop_q       <= eop_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign Get_TX_Packet_Data = get_q;
    assign tx_byte            = byte_q;
    assign tx_byte_valid      = valid_q;
    assign tx_eop             = eop_q;
    assign tx_busy            = busy_q;
    assign tx_done            = done_q;

endmodule

// File: tb/tb_usb_tx_packet_framer.sv
// ---------------------------------------------------------------------------
// Bench for usb_tx_packet_framer. A byte-queue model builds each expected
// packet (SYNC, PID, payload, ~CRC16 low/high) from the request and the
// buffer contents; a negedge process acts as data buffer and serializer,
// drives ready (optionally random), and checks every transferred byte plus
// byte stability under backpressure.
// ---------------------------------------------------------------------------
module tb_usb_tx_packet_framer;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic [1:0] TX_Packet = 2'd0;
    logic [6:0] TX_Packet_Data_Size = 7'd0;
    logic [7:0] TX_Packet_Data = 8'h00;
    logic       ack_received = 1'b0;
    logic       Get_TX_Packet_Data;
    logic [7:0] tx_byte;
    logic       tx_byte_valid;
    logic       tx_byte_ready = 1'b1;
    logic       tx_eop;
    logic       tx_eop_done = 1'b0;
    logic       tx_busy;
    logic       tx_done;

    usb_tx_packet_framer dut (
        .clk                 (clk),
        .n_rst               (n_rst),
        .TX_Packet           (TX_Packet),
        .TX_Packet_Data_Size (TX_Packet_Data_Size),
        .TX_Packet_Data      (TX_Packet_Data),
        .ack_received        (ack_received),
        .Get_TX_Packet_Data  (Get_TX_Packet_Data),
        .tx_byte             (tx_byte),
        .tx_byte_valid       (tx_byte_valid),
        .tx_byte_ready       (tx_byte_ready),
        .tx_eop              (tx_eop),
        .tx_eop_done         (tx_eop_done),
        .tx_busy             (tx_busy),
        .tx_done             (tx_done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] exp_q[$];
    logic [7:0] pay[$];
    int  buf_idx = 0;
    int  get_cnt = 0;
    int  done_cnt = 0;
    int  eop_wait = 0;
    bit  bp_en = 1'b0;
    bit  held_v = 1'b0;
    logic [7:0] held_b = 8'h00;
    bit  tb_toggle = 1'b0;
    bit  tb_last_data = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // CRC16/USB over the first n payload bytes, bit by bit, returned already inverted.
    function automatic logic [15:0] model_crc(input int n);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ pay[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 16'hA001;
            end
        end
        return ~c;
    endfunction

    task automatic expect_packet(input logic [1:0] typ, input int n);
        logic [15:0] c;
        exp_q.push_back(8'h80);
        case (typ)
            2'd3:    exp_q.push_back(8'hD2);
            2'd2:    exp_q.push_back(8'h5A);
            default: exp_q.push_back(tb_toggle ? 8'h4B : 8'hC3);
        endcase
        if (typ == 2'd1) begin
            for (int i = 0; i < n; i++) exp_q.push_back(pay[i]);
            c = model_crc(n);
            exp_q.push_back(c[7:0]);
            exp_q.push_back(c[15:8]);
        end
    endtask

    task automatic fill_random(input int n);
        pay.delete();
        for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
    endtask

    // Buffer + serializer model and per-transfer checker.
    always @(negedge clk) begin
        if (!n_rst) begin
            held_v      = 1'b0;
            tx_eop_done = 1'b0;
            eop_wait    = 0;
        end else begin
            if (held_v) begin
                chk("hold_valid", {31'd0, tx_byte_valid}, 32'd1);
                chk("hold_byte", {24'd0, tx_byte}, {24'd0, held_b});
            end
            tx_byte_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
            held_v = tx_byte_valid && !tx_byte_ready;
            held_b = tx_byte;
            if (tx_byte_valid && tx_byte_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL extra_byte: got %0h, expected no transfer", tx_byte);
                end else begin
                    chk("tx_byte", {24'd0, tx_byte}, {24'd0, exp_q.pop_front()});
                end
            end
            if (tx_byte_valid || tx_eop) chk("busy_in_pkt", {31'd0, tx_busy}, 32'd1);
            if (tx_eop) chk("eop_no_valid", {31'd0, tx_byte_valid}, 32'd0);
            if (Get_TX_Packet_Data) begin
                TX_Packet_Data = (buf_idx < pay.size()) ? pay[buf_idx] : 8'hEE;
                buf_idx++;
                get_cnt++;
            end
            if (tx_eop_done) begin
                tx_eop_done = 1'b0;
            end else if (tx_eop) begin
                eop_wait++;
                if (eop_wait == 3) begin
                    tx_eop_done = 1'b1;
                    eop_wait    = 0;
                end
            end
            if (tx_done) done_cnt++;
        end
    end

    task automatic wait_done(input string nm, input int d0, input int n);
        for (int c = 0; c < 3000 && done_cnt == d0; c++) begin
            @(negedge clk);
            #1;
        end
        chk({nm, "_done"}, done_cnt - d0, 1);
        chk({nm, "_bytes_left"}, exp_q.size(), 0);
        chk({nm, "_gets"}, get_cnt, n);
    endtask

    task automatic run_pkt(input string nm, input logic [1:0] typ, input int sz, input bit hold);
        int n;
        int d0;
        n = (typ == 2'd1) ? ((sz > 64) ? 64 : sz) : 0;
        TX_Packet = 2'd0;
        repeat (2) @(negedge clk);
        buf_idx = 0;
        get_cnt = 0;
        d0 = done_cnt;
        expect_packet(typ, n);
        TX_Packet = typ;
        TX_Packet_Data_Size = 7'(sz);
        @(negedge clk);
        if (!hold) TX_Packet = 2'd0;
        TX_Packet_Data_Size = 7'($urandom);
        wait_done(nm, d0, n);
        tb_last_data = (typ == 2'd1);
    endtask

    task automatic pulse_ack();
        @(negedge clk);
        ack_received = 1'b1;
        @(negedge clk);
        ack_received = 1'b0;
        if (tb_last_data) tb_toggle = ~tb_toggle;
    endtask

    initial begin
        // Pin the CRC model against the CRC-16/USB check value and the empty payload.
        pay = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        chk("crc_model_check", {16'd0, model_crc(9)}, 32'h0000B4C8);
        chk("crc_model_empty", {16'd0, model_crc(0)}, 32'h00000000);

        repeat (3) @(negedge clk);
        #1;
        chk("rst_valid", {31'd0, tx_byte_valid}, 32'd0);
        chk("rst_byte", {24'd0, tx_byte}, 32'd0);
        chk("rst_get", {31'd0, Get_TX_Packet_Data}, 32'd0);
        chk("rst_eop", {31'd0, tx_eop}, 32'd0);
        chk("rst_busy", {31'd0, tx_busy}, 32'd0);
        chk("rst_done", {31'd0, tx_done}, 32'd0);
        @(negedge clk);
        n_rst = 1'b1;

        // T1: ACK, then an ACK from the host that must be ignored.
        run_pkt("t1_ack", 2'd3, 0, 1'b0);
        pulse_ack();

        // T2: zero-length DATA0, CRC bytes 00 00.
        pay.delete();
        expect_packet(2'd1, 0);
        chk("t2_model_crc_lo", {24'd0, exp_q[2]}, 32'h00);
        exp_q.delete();
        run_pkt("t2_zlp", 2'd1, 0, 1'b0);

        // T3 / T4: three-byte DATA0, without and with backpressure.
        pay = '{8'h01, 8'h02, 8'h03};
        run_pkt("t3_data3", 2'd1, 3, 1'b0);
        bp_en = 1'b1;
        run_pkt("t4_bp", 2'd1, 3, 1'b0);
        bp_en = 1'b0;

        // T5: held SEND_DATA does not repeat; ACK flips to DATA1 for the next one.
        fill_random(2);
        run_pkt("t5_held", 2'd1, 2, 1'b1);
        repeat (10) @(negedge clk);
        #1;
        chk("t5_no_retx_busy", {31'd0, tx_busy}, 32'd0);
        chk("t5_no_retx_bytes", exp_q.size(), 0);
        pulse_ack();
        chk("t5_model_toggle", {31'd0, tb_toggle}, 32'd1);
        fill_random(4);
        run_pkt("t5_data1", 2'd1, 4, 1'b0);

        // Randomized packets with random backpressure and host ACKs.
        for (int k = 0; k < 8; k++) begin
            logic [1:0] typ;
            int sz;
            typ = 2'($urandom_range(1, 3));
            sz  = $urandom_range(0, 70);
            fill_random(sz);
            bp_en = 1'($urandom_range(0, 1));
            run_pkt("rand", typ, sz, 1'b0);
            if ($urandom_range(0, 1) == 1) pulse_ack();
        end
        bp_en = 1'b0;

        // T6: oversize request clamps to 64 bytes.
        fill_random(100);
        run_pkt("t6_clamp", 2'd1, 100, 1'b0);

        // T6b: reset in the middle of the payload.
        fill_random(100);
        TX_Packet = 2'd0;
        repeat (2) @(negedge clk);
        buf_idx = 0;
        get_cnt = 0;
        expect_packet(2'd1, 64);
        TX_Packet = 2'd1;
        TX_Packet_Data_Size = 7'd100;
        @(negedge clk);
        TX_Packet = 2'd0;
        begin
            int c;
            c = 0;
            while (!(buf_idx >= 5 && tx_byte_valid) && c < 2000) begin
                @(negedge clk);
                #1;
                c++;
            end
            chk("t6_reach_data", {31'd0, tx_byte_valid}, 32'd1);
        end
        n_rst = 1'b0;
        #1;
        chk("t6_rst_valid", {31'd0, tx_byte_valid}, 32'd0);
        chk("t6_rst_byte", {24'd0, tx_byte}, 32'd0);
        chk("t6_rst_eop", {31'd0, tx_eop}, 32'd0);
        chk("t6_rst_busy", {31'd0, tx_busy}, 32'd0);
        chk("t6_rst_get", {31'd0, Get_TX_Packet_Data}, 32'd0);
        exp_q.delete();
        tb_toggle = 1'b0;
        tb_last_data = 1'b0;
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        run_pkt("t6_nak", 2'd2, 0, 1'b0);

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
